// File: rtl/pll_lock_sequencer.sv
// PLL power-up and lock supervision sequencer, clocked by the free-running refclk.
// The PLL is held in reset for a fixed time. The sequencer then waits for a stable,
// synchronized extlock before it releases the fabric reset. A lock timeout retries
// a bounded number of times. A loss of lock in RUN re-sequences the PLL.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY           = 3,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       extlock,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Terminal counts: the counter starts at zero on entry to a state, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [7:0]       LOL_MAX   = 8'hFF;

  logic             sync1;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       lol_nxt;

  // Two-flop synchronizer that brings the asynchronous extlock into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= extlock;
      lock_s <= sync1;
    end
  end

  // Next-state logic. sw_restart outranks lock changes, and lock changes outrank the terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lol_nxt   = lol_cnt;
    if (sw_restart) begin
      state_nxt = RESET_PLL;
      cnt_nxt   = CNT_ZERO;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == TMO_LAST) begin
            cnt_nxt = CNT_ZERO;
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAIL;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry_cnt + 4'd1;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // A dropout restarts the lock wait but does not count as a retry.
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == STB_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = CNT_ZERO;
            retry_nxt = 4'd0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt_nxt = CNT_ZERO;
          if (!lock_s) begin
            state_nxt = RESET_PLL;
            retry_nxt = 4'd0;
            if (lol_cnt != LOL_MAX) begin
              lol_nxt = lol_cnt + 8'd1;
            end else begin
              lol_nxt = lol_cnt;
            end
          end else begin
            state_nxt = RUN;
          end
        end
        FAIL: begin
          // FAIL is sticky. Only sw_restart or rst_n can leave it.
          state_nxt = FAIL;
          cnt_nxt   = CNT_ZERO;
        end
        default: begin
          state_nxt = RESET_PLL;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // State, counters and outputs. Outputs are decoded from the next state, so they switch with it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= CNT_ZERO;
      retry_cnt <= 4'd0;
      lol_cnt   <= 8'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      lol_cnt   <= lol_nxt;
      pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed, table-driven bench for pll_lock_sequencer. It uses the small parameter set
// 4/8/32/2. Expected values are hand-derived from the sequencing rules, one row per refclk edge.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       extlock = 1'b0;
  logic       sw_restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lol_cnt;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       ext;
    logic       sw;
    logic       pll;
    logic       run;
    logic       fl;
    logic [3:0] retry;
    logic [7:0] lol;
  } vec_t;

  vec_t vt[128];

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRY(2),
    .CNT_W(17)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .extlock(extlock),
    .sw_restart(sw_restart),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .lol_cnt(lol_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check_out(input string name, input logic pll, input logic run,
                           input logic fl, input logic [3:0] retry, input logic [7:0] lol);
    logic [15:0] got;
    logic [15:0] exp;
    got = {pll_rst, sys_rst_n, ready, fail, retry_cnt, lol_cnt};
    exp = {pll, run, run, fl, retry, lol};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {pll_rst,sys_rst_n,ready,fail,retry,lol} got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_row(input int i, input logic ext, input logic pll, input logic run,
                         input logic fl, input logic [3:0] retry, input logic [7:0] lol);
    vt[i].ext   = ext;
    vt[i].sw    = 1'b0;
    vt[i].pll   = pll;
    vt[i].run   = run;
    vt[i].fl    = fl;
    vt[i].retry = retry;
    vt[i].lol   = lol;
  endtask

  task automatic run_table(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      extlock    = vt[i].ext;
      sw_restart = vt[i].sw;
      tick();
      check_out($sformatf("%s[%0d]", tag, i), vt[i].pll, vt[i].run, vt[i].fl, vt[i].retry, vt[i].lol);
    end
    sw_restart = 1'b0;
  endtask

  task automatic restart(input logic ext, input logic [7:0] lol, input string tag);
    extlock    = ext;
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    check_out(tag, 1'b1, 1'b0, 1'b0, 4'd0, lol);
  endtask

  initial begin
    logic [3:0] r;
    logic [7:0] lv;

    // Reset takes effect asynchronously, before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_out("reset_async", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    check_out("reset_hold0", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    check_out("reset_hold1", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b1;

    // 1: nominal bring-up. Row k-1 is edge k. extlock is sampled from edge 11, lock_s is high at edge 12, RUN at edge 21.
    for (int k = 1; k <= 24; k++)
      set_row(k - 1, (k >= 11), (k <= 3), (k >= 21), 1'b0, 4'd0, 8'd0);
    run_table(24, "nominal");

    // 2: glitch. A 5-cycle high, a 1-cycle low, then high again. The stable count restarts, so RUN comes at edge 21, not edge 15.
    restart(1'b0, 8'd0, "glitch_restart");
    for (int k = 1; k <= 22; k++)
      set_row(k - 1, ((k >= 5) && (k <= 9)) || (k >= 11), (k <= 3), (k >= 21), 1'b0, 4'd0, 8'd0);
    run_table(22, "glitch");

    // 3: timeout and retries. pll_rst pulses at edges 1-3, 36-39 and 72-75. FAIL is entered at edge 108, and extlock is ignored after that.
    restart(1'b0, 8'd0, "timeout_restart");
    for (int k = 1; k <= 125; k++) begin
      r = (k < 36) ? 4'd0 : ((k < 72) ? 4'd1 : 4'd2);
      set_row(k - 1, (k >= 116),
              (k <= 3) || ((k >= 36) && (k <= 39)) || ((k >= 72) && (k <= 75)) || (k >= 108),
              1'b0, (k >= 108), r, 8'd0);
    end
    run_table(125, "timeout");

    // 4: recovery from FAIL, with extlock already high.
    restart(1'b1, 8'd0, "recover_restart");
    for (int k = 1; k <= 14; k++)
      set_row(k - 1, 1'b1, (k <= 3), (k >= 13), 1'b0, 4'd0, 8'd0);
    run_table(14, "recover");

    // 5: loss of lock in RUN, repeated 260 times. lol_cnt must saturate at 255.
    for (int it = 1; it <= 260; it++) begin
      for (int k = 0; k <= 16; k++) begin
        lv = ((it - 1 + ((k >= 2) ? 1 : 0)) > 255) ? 8'd255 : 8'((it - 1) + ((k >= 2) ? 1 : 0));
        set_row(k, (k >= 3), (k >= 2) && (k <= 5), (k <= 1) || (k >= 15), 1'b0, 4'd0, lv);
      end
      run_table(17, $sformatf("lol%0d", it));
    end

    // 6: asynchronous reset during STABLE, mid-count. lol_cnt is kept through the restart.
    restart(1'b1, 8'd255, "async_restart");
    for (int k = 1; k <= 8; k++)
      set_row(k - 1, 1'b1, (k <= 3), 1'b0, 1'b0, 4'd0, 8'd255);
    run_table(8, "pre_async");
    #3 rst_n = 1'b0;
    #1 check_out("async_mid", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    check_out("async_hold", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++)
      set_row(k - 1, 1'b1, (k <= 3), (k >= 13), 1'b0, 4'd0, 8'd0);
    run_table(14, "post_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
